ame_num_compare_ctrl: RTL

Initiator-side controller for the AME candidate comparator (`ame_num_compare`). It collects a group of up to six serially produced candidate costs into a slot buffer. It then drives the comparator's `comp_init`/`comp_data` side and waits for `comp_done`. Finally it returns the winning cost and its index to the downstream mode-decision stage over a valid/ready handshake. It sits between the affine cost calculators and the comparator.

---
 rtl/ame_comp_pkg.sv | 17 +
 rtl/ame_cost_slots.sv | 37 +++
 rtl/ame_num_compare_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/ame_comp_pkg.sv
// Shared types and defaults for the AME comparator initiator and the comparator itself.
package ame_comp_pkg;

  localparam int unsigned NUM_CAND_DEF           = 6;
  localparam int unsigned COMP_DATA_BITS_DEF     = 64;
  localparam int unsigned COMP_DATA_IDX_BITS_DEF = 3;

  // Filler for unused slots: never strictly less than a real cost.
  localparam logic [COMP_DATA_BITS_DEF-1:0] PAD_COST = '1;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/ame_cost_slots.sv
// Candidate slot register file with write pointer; clear refills every slot with padding.
module ame_cost_slots
  import ame_comp_pkg::*;
#(
  parameter int unsigned COMP_DATA_BITS = COMP_DATA_BITS_DEF,
  parameter int unsigned NUM_CAND       = NUM_CAND_DEF,
  parameter int unsigned CNT_W          = $clog2(NUM_CAND + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               clear_i,
  input  logic                               wr_en_i,
  input  logic [COMP_DATA_BITS-1:0]          wr_data_i,
  output logic [CNT_W-1:0]                   cnt_o,
  output logic [NUM_CAND*COMP_DATA_BITS-1:0] data_o
);

  logic [NUM_CAND-1:0][COMP_DATA_BITS-1:0] slots_q;
  logic [CNT_W-1:0]                        cnt_q;

  // Slot writes at the pointer; reset and clear restore padding and rewind the pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      slots_q <= '1;
      cnt_q   <= '0;
    end else if (wr_en_i) begin
      for (int unsigned i = 0; i < NUM_CAND; i++) begin
        if (cnt_q == CNT_W'(i)) slots_q[i] <= wr_data_i;
      end
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o  = cnt_q;
  assign data_o = slots_q;

endmodule

// File: rtl/ame_num_compare_ctrl.sv
// Initiator-side controller for ame_num_compare: collect a cost group, run the
// comparator, return the winner over valid/ready.
// Optional watchdog on the comparator wait: define AME_COMP_TIMEOUT_EN.
module ame_num_compare_ctrl
  import ame_comp_pkg::*;
#(
  parameter int unsigned COMP_DATA_BITS     = COMP_DATA_BITS_DEF,
  parameter int unsigned COMP_DATA_IDX_BITS = COMP_DATA_IDX_BITS_DEF,
  parameter int unsigned NUM_CAND           = NUM_CAND_DEF,
  parameter int unsigned TIMEOUT_CYCLES     = 32
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               cost_valid_i,
  output logic                               cost_ready_o,
  input  logic [COMP_DATA_BITS-1:0]          cost_data_i,
  input  logic                               cost_last_i,
  output logic                               comp_init_o,
  output logic [NUM_CAND*COMP_DATA_BITS-1:0] comp_data_o,
  input  logic                               comp_done_i,
  input  logic [COMP_DATA_BITS-1:0]          comp_data_i,
  input  logic [COMP_DATA_IDX_BITS-1:0]      comp_data_idx_i,
  output logic                               best_valid_o,
  input  logic                               best_ready_i,
  output logic [COMP_DATA_BITS-1:0]          best_data_o,
  output logic [COMP_DATA_IDX_BITS-1:0]      best_idx_o,
  output logic                               best_err_o
);

  localparam int unsigned CNT_W = $clog2(NUM_CAND + 1);

  if (NUM_CAND > (1 << COMP_DATA_IDX_BITS) || NUM_CAND == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("ame_num_compare_ctrl: invalid NUM_CAND/COMP_DATA_IDX_BITS/TIMEOUT_CYCLES");
  end

  ctrl_state_e                   state_q;
  logic                          cost_ready_q;
  logic                          comp_init_q;
  logic                          best_valid_q;
  logic [COMP_DATA_BITS-1:0]     best_data_q;
  logic [COMP_DATA_IDX_BITS-1:0] best_idx_q;
  logic [CNT_W-1:0]              cnt;
  logic                          xfer;
  logic                          close;
  logic                          clear;

  assign xfer  = (state_q == ST_FILL) && cost_valid_i && cost_ready_q;
  assign close = xfer && (cost_last_i || (cnt == CNT_W'(NUM_CAND - 1)));
  assign clear = (state_q == ST_HOLD) && best_ready_i;

  ame_cost_slots #(
    .COMP_DATA_BITS (COMP_DATA_BITS),
    .NUM_CAND       (NUM_CAND),
    .CNT_W          (CNT_W)
  ) u_slots (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (clear),
    .wr_en_i   (xfer),
    .wr_data_i (cost_data_i),
    .cnt_o     (cnt),
    .data_o    (comp_data_o)
  );

`ifdef AME_COMP_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;
  logic            best_err_q;
`endif

  // Group FSM with registered handshake outputs (and watchdog when enabled).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_FILL;
      cost_ready_q <= 1'b0;
      comp_init_q  <= 1'b0;
      best_valid_q <= 1'b0;
      best_data_q  <= '0;
      best_idx_q   <= '0;
`ifdef AME_COMP_TIMEOUT_EN
      wd_q         <= '0;
      best_err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_FILL: begin
          if (close) begin
            state_q      <= ST_WAIT;
            cost_ready_q <= 1'b0;
            comp_init_q  <= 1'b1;
`ifdef AME_COMP_TIMEOUT_EN
            wd_q         <= '0;
`endif
          end else begin
            cost_ready_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (comp_done_i) begin
            state_q      <= ST_HOLD;
            comp_init_q  <= 1'b0;
            best_valid_q <= 1'b1;
            best_data_q  <= comp_data_i;
            best_idx_q   <= comp_data_idx_i;
          end
`ifdef AME_COMP_TIMEOUT_EN
          else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            state_q      <= ST_HOLD;
            comp_init_q  <= 1'b0;
            best_valid_q <= 1'b1;
            best_data_q  <= '1;
            best_idx_q   <= '0;
            best_err_q   <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
`endif
        end
        ST_HOLD: begin
          if (best_ready_i) begin
            state_q      <= ST_FILL;
            best_valid_q <= 1'b0;
            cost_ready_q <= 1'b1;
`ifdef AME_COMP_TIMEOUT_EN
            best_err_q   <= 1'b0;
`endif
          end
        end
        default: state_q <= ST_FILL;
      endcase
    end
  end

  assign cost_ready_o = cost_ready_q;
  assign comp_init_o  = comp_init_q;
  assign best_valid_o = best_valid_q;
  assign best_data_o  = best_data_q;
  assign best_idx_o   = best_idx_q;
`ifdef AME_COMP_TIMEOUT_EN
  assign best_err_o   = best_err_q;
`else
  assign best_err_o   = 1'b0;
`endif

endmodule
